rcv_control: RTL
================

# rcv_control

Receive control unit for the serial receiver. It synchronises `serial_in` and detects the start-bit falling edge. It sequences a packet by enabling the bit timer until `packet_done`, checks the stop bit, and loads the receive buffer. It also keeps the `data_ready`, `framing_error` and `overrun_error` status for the host side. It sits between the serial line and the bit timer / shift-register datapath, and consumes the timer's `packet_done`.

## Interface
- Parameters: none (2-stage synchroniser and state encoding are fixed).
- `clk`  input  1  system clock, all logic rising-edge.
- `n_rst`  input  1  asynchronous active-low reset.
- `serial_in`  input  1  raw serial line, idle high, asynchronous to `clk`.
- `packet_done`  input  1  from the bit timer; high when the 9-bit frame (8 data + stop) has been sampled.
- `stop_bit`  input  1  last sampled bit from the receive shift register, valid when `packet_done` is high.
- `data_read`  input  1  host acknowledges/consumes the buffered byte (level, sampled each cycle).
- `enable_timer`  output  1  run bit timer / sampling.
- `sbc_clear`  output  1  one-cycle clear of timer, shift register and error flags at frame start.
- `load_buffer`  output  1  one-cycle load of shift-register data into the receive buffer.
- `data_ready`  output  1  buffered byte valid, not yet read.
- `framing_error`  output  1  last frame had stop bit = 0.
- `overrun_error`  output  1  a new byte was loaded over an unread one.

## Operation
- Synchroniser: `sync1` → `sync2` → `sync_prev`, all reset to 1. `start_det = sync_prev & ~sync2` (combinational), evaluated only in IDLE.
- FSM states: IDLE, CLEAR, RECEIVE, CHECK, LOAD. Reset state is IDLE.
  - IDLE: go to CLEAR when `start_det` is 1, otherwise stay.
  - CLEAR: `sbc_clear`=1. Always go to RECEIVE.
  - RECEIVE: `enable_timer`=1. Go to CHECK when `packet_done`=1, otherwise stay.
  - CHECK: all strobes 0. Go to LOAD if `stop_bit`=1. If `stop_bit`=0, set `framing_error` and go to IDLE with no load.
  - LOAD: `load_buffer`=1. Always go to IDLE.
- Output decode: `enable_timer`, `sbc_clear` and `load_buffer` are pure Moore decodes of the state register.
- `framing_error`: set on the CHECK→IDLE error transition. Cleared when in CLEAR (next frame start). Holds otherwise.
- `data_ready` / `overrun_error`, evaluated each edge:
  - LOAD with `data_ready`=1 and `data_read`=0: `overrun_error`←1, `data_ready` stays 1.
  - LOAD otherwise: `data_ready`←1.
  - Not LOAD and `data_read`=1: `data_ready`←0 and `overrun_error`←0.
- Falling edges on the line outside IDLE are ignored. No restart occurs mid-frame.
- A false start (glitch) is not filtered here. The frame completes and stop-bit checking flags it.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and the synchroniser flops are 1. Reset mid-frame aborts immediately with no load and no flags.
- Start-detection latency, with the line falling before edge k:
  - Edge k+1: `start_det` goes high (one cycle).
  - Edge k+2: FSM enters CLEAR; `sbc_clear` is high for that cycle.
  - Edge k+3: RECEIVE; `enable_timer` is high.
- With `packet_done` high at edge m:
  - Edge m: CHECK; `enable_timer` drops after m.
  - Edge m+1: LOAD, or IDLE with `framing_error`=1.
  - Edge m+2: IDLE, `data_ready`=1.
- Minimum frame-to-frame gap: the next start edge is accepted on the first IDLE cycle.
- `packet_done` is level-sensitive, sampled only in RECEIVE.
- `stop_bit` is sampled only in CHECK.

## Test plan
- Reset: hold `n_rst`=0 with `serial_in` toggling. All outputs stay 0. After release with the line high, the FSM stays in IDLE.
- Good frame: line falls at edge k, `packet_done` asserted at m with `stop_bit`=1.
  - Response: `sbc_clear` high only in cycle k+2, `enable_timer` high from k+3 to m, `load_buffer` high in cycle m+1, `data_ready`=1 from m+2.
  - `data_read`=1 for one cycle then clears `data_ready`.
- Framing error: same stimulus with `stop_bit`=0.
  - Response: no `load_buffer`, `framing_error`=1 after m+1 and held through IDLE.
  - The next frame's CLEAR cycle returns it to 0.
- Overrun: two good frames back-to-back, `data_read` held 0.
  - Response: at the second LOAD, `overrun_error`=1 and `data_ready` stays 1.
  - `data_read`=1 then clears both.
- Simultaneous LOAD and `data_read`=1 with `data_ready`=1: `data_ready` stays 1 and `overrun_error` stays 0.
- Mid-frame edges and reset:
  - Toggle `serial_in` during RECEIVE: no state change and `sbc_clear` is not reasserted.
  - Assert `n_rst`=0 during RECEIVE: `enable_timer` drops asynchronously, and after release the FSM is in IDLE with all flags 0.

Source files
------------

// File: rtl/rcv_control_if.sv
// rcv_control_if
//   Groups the receive controller's links to the bit timer / shift-register
//   datapath and to the host-side status.
//   master : timer/datapath/host side, drives packet_done, stop_bit, data_read
//   slave  : rcv_control, drives the strobes and status flags
//   packet_done   timer: 9-bit frame fully sampled
//   stop_bit      shift register: last sampled bit (valid with packet_done)
//   data_read     host consumes the buffered byte (level)
//   enable_timer  run bit timer / sampling
//   sbc_clear     one-cycle clear at frame start
//   load_buffer   one-cycle load of shift data into the receive buffer
//   data_ready    buffered byte valid and unread
//   framing_error last frame had stop bit = 0
//   overrun_error a byte was loaded over an unread one
interface rcv_control_if;
   logic packet_done;
   logic stop_bit;
   logic data_read;
   logic enable_timer;
   logic sbc_clear;
   logic load_buffer;
   logic data_ready;
   logic framing_error;
   logic overrun_error;

   modport master (
      output packet_done, stop_bit, data_read,
      input  enable_timer, sbc_clear, load_buffer,
             data_ready, framing_error, overrun_error
   );

   modport slave (
      input  packet_done, stop_bit, data_read,
      output enable_timer, sbc_clear, load_buffer,
             data_ready, framing_error, overrun_error
   );
endinterface

// File: rtl/rcv_control.sv
// rcv_control
//   Receive control for the serial receiver: synchronises serial_in, detects
//   the start-bit falling edge, sequences a frame through the bit timer,
//   checks the stop bit, loads the receive buffer and keeps host status.
//   clk        system clock, rising edge
//   n_rst      asynchronous active-low reset
//   serial_in  raw serial line, idle high, asynchronous to clk
//   bus        rcv_control_if.slave: timer/datapath handshake and status
module rcv_control (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             serial_in,
   rcv_control_if.slave     bus
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RECEIVE,
      CHECK,
      LOAD
   } state_t;

   state_t state_q, state_d;

   logic sync1_q, sync2_q, sync_prev_q;
   logic start_det;

   logic framing_error_q, framing_error_d;
   logic data_ready_q,    data_ready_d;
   logic overrun_error_q, overrun_error_d;

   // Two-stage synchroniser plus one history flop for edge detection.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         sync_prev_q <= 1'b1;
      end else begin
         sync1_q     <= serial_in;
         sync2_q     <= sync1_q;
         sync_prev_q <= sync2_q;
      end
   end

   assign start_det = sync_prev_q & ~sync2_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q         <= IDLE;
         framing_error_q <= 1'b0;
         data_ready_q    <= 1'b0;
         overrun_error_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         framing_error_q <= framing_error_d;
         data_ready_q    <= data_ready_d;
         overrun_error_q <= overrun_error_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      framing_error_d = framing_error_q;
      unique case (state_q)
         IDLE: begin
            if (start_det) state_d = CLEAR;
         end
         CLEAR: begin
            framing_error_d = 1'b0;
            state_d         = RECEIVE;
         end
         RECEIVE: begin
            if (bus.packet_done) state_d = CHECK;
         end
         CHECK: begin
            if (bus.stop_bit) begin
               state_d = LOAD;
            end else begin
               framing_error_d = 1'b1;
               state_d         = IDLE;
            end
         end
         LOAD: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A load over an unread byte keeps data_ready and flags overrun; a load
   // that coincides with data_read simply refreshes data_ready.
   always_comb begin
      data_ready_d    = data_ready_q;
      overrun_error_d = overrun_error_q;
      if (state_q == LOAD) begin
         if (data_ready_q && !bus.data_read) overrun_error_d = 1'b1;
         else                                data_ready_d    = 1'b1;
      end else if (bus.data_read) begin
         data_ready_d    = 1'b0;
         overrun_error_d = 1'b0;
      end
   end

   assign bus.enable_timer  = (state_q == RECEIVE);
   assign bus.sbc_clear     = (state_q == CLEAR);
   assign bus.load_buffer   = (state_q == LOAD);
   assign bus.framing_error = framing_error_q;
   assign bus.data_ready    = data_ready_q;
   assign bus.overrun_error = overrun_error_q;

endmodule
